// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
package mem_wb_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_RA_W  = 5;
    localparam int DEF_SEL_W = 2;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DMEM = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Payload at the default widths; mem_wb_stage builds the same layout
    // from its own parameters.
    typedef struct packed {
        logic [DEF_XLEN-1:0]  alu_res;
        logic [DEF_XLEN-1:0]  dm_q;
        logic [DEF_XLEN-1:0]  pc4;
        logic [DEF_SEL_W-1:0] sel;
        logic [DEF_RA_W-1:0]  rd;
        logic                 we;
    } mem_wb_payload_t;

    localparam logic [DEF_RA_W-1:0] RF_ZERO = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (head + skid) with valid/ready handshake and flush.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  OCC_EMPTY | nothing buffered, out_valid low
//  OCC_ONE   | head holds the oldest entry, skid unused
//  OCC_FULL  | head and skid both hold entries, in_ready low
//
// in_ready is registered from the next state so there is no combinational
// path from out_ready to in_ready.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter type T = logic
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flush,
    input  logic i_in_valid,
    output logic o_in_ready,
    input  T     i_in_data,
    output logic o_out_valid,
    input  logic i_out_ready,
    output T     o_out_data
);

    occ_state_e r_state;
    occ_state_e w_state_nxt;
    T           r_head;
    T           r_skid;
    logic       r_ready;
    logic       w_accept;
    logic       w_pop;
    logic       w_load_head_in;
    logic       w_load_head_skid;
    logic       w_load_skid;

    assign w_accept = i_in_valid & r_ready;
    assign w_pop    = (r_state != OCC_EMPTY) & i_out_ready;

    // Next occupancy and which register loads from where.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = OCC_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = OCC_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = OCC_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = OCC_EMPTY;
        endcase
        // Flush wins over accept and pop; payload loads are harmless since
        // nothing is marked valid afterwards.
        if (i_flush) begin
            w_state_nxt = OCC_EMPTY;
        end
    end

    // Occupancy state and registered ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= OCC_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != OCC_FULL);
        end
    end

    // Payload registers: head takes new input or the skid entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= i_in_data;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_ready;
    assign o_out_valid = (r_state != OCC_EMPTY);
    assign o_out_data  = r_head;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: skid-buffered handshake, write-back select,
// register-file write port and EX forwarding tap.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int SEL_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_mem_valid,
    output logic             o_mem_ready,
    input  logic [XLEN-1:0]  i_mem_alu_res,
    input  logic [XLEN-1:0]  i_mem_dm_q,
    input  logic [XLEN-1:0]  i_mem_pc4,
    input  logic [SEL_W-1:0] i_mem_rf_d_sel,
    input  logic [RA_W-1:0]  i_mem_rd,
    input  logic             i_mem_rf_we,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic             o_wb_rf_we,
    output logic [RA_W-1:0]  o_wb_rd,
    output logic [XLEN-1:0]  o_wb_data,
    output logic             o_fwd_valid,
    output logic [RA_W-1:0]  o_fwd_rd,
    output logic [XLEN-1:0]  o_fwd_data
);

    typedef struct packed {
        logic [XLEN-1:0]  alu_res;
        logic [XLEN-1:0]  dm_q;
        logic [XLEN-1:0]  pc4;
        logic [SEL_W-1:0] sel;
        logic [RA_W-1:0]  rd;
        logic             we;
    } payload_t;

    payload_t        w_in;
    payload_t        w_head;
    logic            w_valid;
    logic [XLEN-1:0] w_sel_data;

    assign w_in.alu_res = i_mem_alu_res;
    assign w_in.dm_q    = i_mem_dm_q;
    assign w_in.pc4     = i_mem_pc4;
    assign w_in.sel     = i_mem_rf_d_sel;
    assign w_in.rd      = i_mem_rd;
    assign w_in.we      = i_mem_rf_we;

    pipe_skid_buf #(
        .T (payload_t)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_in_valid  (i_mem_valid),
        .o_in_ready  (o_mem_ready),
        .i_in_data   (w_in),
        .o_out_valid (w_valid),
        .i_out_ready (i_wb_ready),
        .o_out_data  (w_head)
    );

    // Write-back data select from the head entry; reserved code gives zero.
    always_comb begin
        w_sel_data = '0;
        case (w_head.sel)
            SEL_W'(WB_ALU):  w_sel_data = w_head.alu_res;
            SEL_W'(WB_DMEM): w_sel_data = w_head.dm_q;
            SEL_W'(WB_PC4):  w_sel_data = w_head.pc4;
            default:         w_sel_data = '0;
        endcase
    end

    // Head payload is not cleared on flush, so every output is gated by valid.
    assign o_wb_valid  = w_valid;
    assign o_wb_rf_we  = w_valid & w_head.we & (w_head.rd != RA_W'(RF_ZERO));
    assign o_wb_rd     = w_valid ? w_head.rd : '0;
    assign o_wb_data   = w_valid ? w_sel_data : '0;

    assign o_fwd_valid = o_wb_rf_we;
    assign o_fwd_rd    = o_wb_rd;
    assign o_fwd_data  = o_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_wb_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [31:0] i_mem_alu_res;
    logic [31:0] i_mem_dm_q;
    logic [31:0] i_mem_pc4;
    logic [1:0]  i_mem_rf_d_sel;
    logic [4:0]  i_mem_rd;
    logic        i_mem_rf_we;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic        o_wb_rf_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_rd;
    logic [31:0] o_fwd_data;

    int checks = 0;
    int errors = 0;

    mem_wb_stage dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_mem_valid    (i_mem_valid),
        .o_mem_ready    (o_mem_ready),
        .i_mem_alu_res  (i_mem_alu_res),
        .i_mem_dm_q     (i_mem_dm_q),
        .i_mem_pc4      (i_mem_pc4),
        .i_mem_rf_d_sel (i_mem_rf_d_sel),
        .i_mem_rd       (i_mem_rd),
        .i_mem_rf_we    (i_mem_rf_we),
        .o_wb_valid     (o_wb_valid),
        .i_wb_ready     (i_wb_ready),
        .o_wb_rf_we     (o_wb_rf_we),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_fwd_valid    (o_fwd_valid),
        .o_fwd_rd       (o_fwd_rd),
        .o_fwd_data     (o_fwd_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] pc4;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t q[$];
    bit   m_ready = 1'b0;
    bit   m_init  = 1'b0;

    function automatic logic [31:0] ent_data(input ent_t e);
        case (e.sel)
            2'd0:    return e.alu;
            2'd1:    return e.dm;
            2'd2:    return e.pc4;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge i_clk) begin
        ent_t e;
        bit   acc;
        bit   pop;
        m_init = 1'b1;
        if (i_rst) begin
            q.delete();
            m_ready = 1'b0;
        end else if (i_flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = i_mem_valid && m_ready;
            pop = (q.size() > 0) && i_wb_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.alu = i_mem_alu_res;
                e.dm  = i_mem_dm_q;
                e.pc4 = i_mem_pc4;
                e.sel = i_mem_rf_d_sel;
                e.rd  = i_mem_rd;
                e.we  = i_mem_rf_we;
                q.push_back(e);
            end
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge i_clk) begin
        logic        ev;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ed;
        if (m_init) begin
            ev  = (q.size() > 0);
            ewe = 1'b0;
            erd = 5'd0;
            ed  = 32'd0;
            if (ev) begin
                ewe = q[0].we && (q[0].rd != 5'd0);
                erd = q[0].rd;
                ed  = ent_data(q[0]);
            end
            chk("mdl_mem_ready", o_mem_ready, m_ready);
            chk("mdl_wb_valid",  o_wb_valid,  ev);
            chk("mdl_wb_rf_we",  o_wb_rf_we,  ewe);
            chk("mdl_wb_rd",     o_wb_rd,     erd);
            chk("mdl_wb_data",   o_wb_data,   ed);
            chk("mdl_fwd_valid", o_fwd_valid, ewe);
            chk("mdl_fwd_rd",    o_fwd_rd,    erd);
            chk("mdl_fwd_data",  o_fwd_data,  ed);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] pc4, input logic [1:0] sel,
                         input logic [4:0] rd, input logic we);
        i_mem_valid    = v;
        i_mem_alu_res  = alu;
        i_mem_dm_q     = dm;
        i_mem_pc4      = pc4;
        i_mem_rf_d_sel = sel;
        i_mem_rd       = rd;
        i_mem_rf_we    = we;
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_flush = 1'b0;
        i_wb_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();
        cyc();
        chk("rst_mem_ready", o_mem_ready, 1'b0);
        chk("rst_wb_valid",  o_wb_valid,  1'b0);
        chk("rst_wb_data",   o_wb_data,   32'h0);
        i_rst = 1'b0;
        cyc();
        chk("post_rst_ready", o_mem_ready, 1'b1);

        // 1: stream with no stall, one-cycle latency
        i_wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h11 * (i + 1), 32'h0, 32'h0, 2'd0, 5'(i + 1), 1'b1);
            cyc();
            chk("stream_valid", o_wb_valid, 1'b1);
            chk("stream_data",  o_wb_data,  32'h11 * (i + 1));
            chk("stream_rd",    o_wb_rd,    5'(i + 1));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();
        chk("stream_drained", o_wb_valid, 1'b0);

        // 2: back-pressure with A, B, C
        i_wb_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h0, 32'h0, 2'd0, 5'd6, 1'b1);
        cyc();
        chk("bp_ready_after_a", o_mem_ready, 1'b1);
        drive(1'b1, 32'hB, 32'h0, 32'h0, 2'd0, 5'd7, 1'b1);
        cyc();
        chk("bp_ready_after_b", o_mem_ready, 1'b0);
        chk("bp_head_a",        o_wb_data,   32'hA);
        drive(1'b1, 32'hC, 32'h0, 32'h0, 2'd0, 5'd8, 1'b1);
        cyc();
        chk("bp_c_held_ready", o_mem_ready, 1'b0);
        chk("bp_head_still_a", o_wb_data,   32'hA);
        i_wb_ready = 1'b1;
        cyc();
        chk("bp_head_b",       o_wb_data,   32'hB);
        chk("bp_ready_return", o_mem_ready, 1'b1);
        cyc();
        chk("bp_head_c", o_wb_data, 32'hC);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();
        chk("bp_drained", o_wb_valid, 1'b0);

        // 3: write-back select
        drive(1'b1, 32'h1, 32'hDEADBEEF, 32'h2, 2'd1, 5'd9, 1'b1);
        cyc();
        chk("sel_dmem", o_wb_data, 32'hDEADBEEF);
        drive(1'b1, 32'h1, 32'h3, 32'h104, 2'd2, 5'd9, 1'b1);
        cyc();
        chk("sel_pc4", o_wb_data, 32'h104);
        drive(1'b1, 32'h77, 32'h88, 32'h99, 2'd3, 5'd9, 1'b1);
        cyc();
        chk("sel_rsvd",       o_wb_data,  32'h0);
        chk("sel_rsvd_valid", o_wb_valid, 1'b1);

        // 4: register 0 writes are suppressed but still pop
        drive(1'b1, 32'h55, 32'h0, 32'h0, 2'd0, 5'd0, 1'b1);
        cyc();
        chk("r0_valid",     o_wb_valid,  1'b1);
        chk("r0_rf_we",     o_wb_rf_we,  1'b0);
        chk("r0_fwd_valid", o_fwd_valid, 1'b0);
        drive(1'b1, 32'h66, 32'h0, 32'h0, 2'd0, 5'd5, 1'b0);
        cyc();
        chk("we0_rf_we", o_wb_rf_we, 1'b0);
        chk("we0_data",  o_wb_data,  32'h66);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();

        // 5: flush while FULL with a new entry presented
        i_wb_ready = 1'b0;
        drive(1'b1, 32'hD0, 32'h0, 32'h0, 2'd0, 5'd10, 1'b1);
        cyc();
        drive(1'b1, 32'hE0, 32'h0, 32'h0, 2'd0, 5'd11, 1'b1);
        cyc();
        chk("fl_full", o_mem_ready, 1'b0);
        i_flush = 1'b1;
        drive(1'b1, 32'hF0, 32'h0, 32'h0, 2'd0, 5'd12, 1'b1);
        cyc();
        chk("fl_wb_valid",  o_wb_valid,  1'b0);
        chk("fl_mem_ready", o_mem_ready, 1'b1);
        i_flush = 1'b0;
        i_wb_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();
        chk("fl_stays_empty", o_wb_valid, 1'b0);

        // 6: reset while FULL (first reset cycle also flushes)
        i_wb_ready = 1'b0;
        drive(1'b1, 32'h60, 32'h0, 32'h0, 2'd0, 5'd13, 1'b1);
        cyc();
        drive(1'b1, 32'h61, 32'h0, 32'h0, 2'd0, 5'd14, 1'b1);
        cyc();
        i_rst = 1'b1;
        i_flush = 1'b1;
        cyc();
        chk("rst6_ready_a", o_mem_ready, 1'b0);
        chk("rst6_valid_a", o_wb_valid,  1'b0);
        i_flush = 1'b0;
        cyc();
        chk("rst6_ready_b", o_mem_ready, 1'b0);
        chk("rst6_rd_b",    o_wb_rd,     5'd0);
        chk("rst6_we_b",    o_wb_rf_we,  1'b0);
        i_rst = 1'b0;
        i_wb_ready = 1'b1;
        drive(1'b1, 32'h6A, 32'h0, 32'h0, 2'd0, 5'd15, 1'b1);
        cyc();
        chk("rst6_ready_up", o_mem_ready, 1'b1);
        chk("rst6_no_entry", o_wb_valid,  1'b0);
        cyc();
        chk("rst6_latency", o_wb_data, 32'h6A);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        cyc();

        // mixed traffic, checked by the model only
        for (int i = 0; i < 40; i++) begin
            drive((i % 3) != 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i),
                  2'(i % 4), 5'(i % 32), (i % 2) == 0);
            i_wb_ready = ((i % 5) != 1) && ((i % 7) != 3);
            i_flush = (i == 23);
            cyc();
        end
        i_flush = 1'b0;
        i_wb_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
        repeat (3) cyc();
        chk("final_empty", o_wb_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
